// File: rtl/fft_frame_scheduler_if.sv
// Bundle of the sample, FFT sink, FFT source and band-output signals of fft_frame_scheduler.
// The slave modport is the scheduler itself; master is the surrounding audio/FFT environment.
interface fft_frame_scheduler_if #(
    parameter int unsigned NUM_BANDS = 4,
    parameter int unsigned ACC_W     = 24
);
    // Audio sample path
    logic                         i_sample_valid;
    logic [15:0]                  i_sample;
    // FFT sink (towards the core)
    logic                         o_sink_valid;
    logic                         i_sink_ready;
    logic                         o_sink_sop;
    logic                         o_sink_eop;
    logic [15:0]                  o_sink_real;
    // FFT source (from the core)
    logic                         i_src_valid;
    logic                         i_src_sop;
    logic                         i_src_eop;
    logic [15:0]                  i_src_real;
    logic [15:0]                  i_src_imag;
    logic                         o_src_ready;
    // Band results and status
    logic [NUM_BANDS*ACC_W-1:0]   o_bands;
    logic                         o_bands_valid;
    logic                         o_overflow;
    logic                         o_frame_err;

    modport slave (
        input  i_sample_valid, i_sample, i_sink_ready,
        input  i_src_valid, i_src_sop, i_src_eop, i_src_real, i_src_imag,
        output o_sink_valid, o_sink_sop, o_sink_eop, o_sink_real, o_src_ready,
        output o_bands, o_bands_valid, o_overflow, o_frame_err
    );

    modport master (
        output i_sample_valid, i_sample, i_sink_ready,
        output i_src_valid, i_src_sop, i_src_eop, i_src_real, i_src_imag,
        input  o_sink_valid, o_sink_sop, o_sink_eop, o_sink_real, o_src_ready,
        input  o_bands, o_bands_valid, o_overflow, o_frame_err
    );
endinterface

// File: rtl/fft_frame_scheduler.sv
// Sample FIFO feeding gap-free FRAME_LEN-sample frames into a streaming FFT, and reduction of
// the lower half-spectrum coming back into NUM_BANDS magnitude bands.
// Optional build macro FFT_SCHED_PEAKHOLD_EN: committed bands become
// max(new, old - old/8) instead of the raw new sums.
module fft_frame_scheduler #(
    parameter int unsigned FRAME_LEN = 512,
    parameter int unsigned FIFO_AW   = 10,
    parameter int unsigned NUM_BANDS = 4,
    parameter int unsigned ACC_W     = 24
) (
    input logic                  i_clk,
    input logic                  i_rst,
    fft_frame_scheduler_if.slave bus
);
    localparam int unsigned Depth     = 2 ** FIFO_AW;
    localparam int unsigned CntW      = FIFO_AW + 1;
    localparam int unsigned BinW      = $clog2(FRAME_LEN);
    localparam int unsigned BandShift = $clog2(FRAME_LEN / (2 * NUM_BANDS));

    localparam logic [CntW-1:0]  FrameLenCnt = CntW'(FRAME_LEN);
    localparam logic [CntW-1:0]  DepthCnt    = CntW'(Depth);
    localparam logic [BinW-1:0]  LastBin     = BinW'(FRAME_LEN - 1);
    localparam logic [ACC_W-1:0] AccMax      = '1;

    typedef enum logic [0:0] {StWait, StSend} state_e;

    // ---------------- Sample FIFO ----------------
    logic [15:0]        mem_q [Depth];
    logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q, rd_ptr_nxt;
    logic [CntW-1:0]    count_q, count_d;
    logic               push, pop, overflow_q;
    state_e             state_q;

    assign push       = bus.i_sample_valid && (count_q != DepthCnt);
    // valid is always high in StSend, so a ready there completes a beat
    assign pop        = (state_q == StSend) && bus.i_sink_ready;
    assign rd_ptr_nxt = rd_ptr_q + FIFO_AW'(1);

    // Occupancy after this cycle's push/pop
    always_comb begin
        count_d = count_q + CntW'(push) - CntW'(pop);
    end

    // Sample storage, no reset needed
    always_ff @(posedge i_clk) begin
        if (push) mem_q[wr_ptr_q] <= bus.i_sample;
    end

    // FIFO pointers, count and sticky overflow
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + FIFO_AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_nxt;
            count_q <= count_d;
            if (bus.i_sample_valid && (count_q == DepthCnt)) overflow_q <= 1'b1;
        end
    end

    // ---------------- Sink FSM ----------------
    logic [BinW-1:0] beat_q, beat_nxt;
    logic            sink_valid_q, sink_sop_q, sink_eop_q;
    logic [15:0]     sink_real_q;

    assign beat_nxt = beat_q + BinW'(1);

    // Frame sequencer; outputs are registered and prefetch the next FIFO head on each beat
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q      <= StWait;
            beat_q       <= '0;
            sink_valid_q <= 1'b0;
            sink_sop_q   <= 1'b0;
            sink_eop_q   <= 1'b0;
            sink_real_q  <= '0;
        end else begin
            unique case (state_q)
                StWait: begin
                    if (count_q >= FrameLenCnt) begin
                        state_q      <= StSend;
                        beat_q       <= '0;
                        sink_valid_q <= 1'b1;
                        sink_sop_q   <= 1'b1;
                        sink_eop_q   <= 1'b0;
                        sink_real_q  <= mem_q[rd_ptr_q];
                    end
                end
                StSend: begin
                    if (bus.i_sink_ready) begin
                        if (beat_q == LastBin) begin
                            state_q      <= StWait;
                            beat_q       <= '0;
                            sink_valid_q <= 1'b0;
                            sink_sop_q   <= 1'b0;
                            sink_eop_q   <= 1'b0;
                        end else begin
                            beat_q      <= beat_nxt;
                            sink_sop_q  <= 1'b0;
                            sink_eop_q  <= (beat_nxt == LastBin);
                            sink_real_q <= mem_q[rd_ptr_nxt];
                        end
                    end
                end
                default: state_q <= StWait;
            endcase
        end
    end

    // ---------------- Source band reduction ----------------
    logic [ACC_W-1:0]           acc_q [NUM_BANDS];
    logic [ACC_W-1:0]           acc_d [NUM_BANDS];
    logic [BinW-1:0]            bin_q, bin_d, bin_eff;
    logic                       in_frame_q, in_frame_d;
    logic [NUM_BANDS*ACC_W-1:0] bands_q, bands_d;
    logic                       bands_valid_q, bands_valid_d;
    logic                       frame_err_q, frame_err_d;
    logic                       src_ready_q, src_beat;
    logic [16:0]                mag;
    logic [ACC_W:0]             sum;

    function automatic logic [16:0] abs16(input logic [15:0] v);
        logic [16:0] ext;
        ext = {v[15], v};
        return v[15] ? (~ext + 17'd1) : ext;
    endfunction

`ifdef FFT_SCHED_PEAKHOLD_EN
    function automatic logic [ACC_W-1:0] peak_hold(input logic [ACC_W-1:0] new_v,
                                                   input logic [ACC_W-1:0] old_v);
        logic [ACC_W-1:0] decayed;
        decayed = old_v - (old_v >> 3);
        return (new_v > decayed) ? new_v : decayed;
    endfunction
`endif

    assign src_beat = bus.i_src_valid && src_ready_q;
    assign mag      = abs16(bus.i_src_real) + abs16(bus.i_src_imag);

    // Accumulate one bin per beat; sop restarts, a well-formed eop commits
    always_comb begin
        acc_d         = acc_q;
        bin_d         = bin_q;
        in_frame_d    = in_frame_q;
        bands_d       = bands_q;
        bands_valid_d = 1'b0;
        frame_err_d   = 1'b0;
        sum           = '0;
        bin_eff       = bus.i_src_sop ? '0 : bin_q;
        if (src_beat) begin
            if (!bus.i_src_sop && !in_frame_q) begin
                frame_err_d = 1'b1;
            end else begin
                for (int b = 0; b < NUM_BANDS; b++) begin
                    acc_d[b] = bus.i_src_sop ? '0 : acc_q[b];
                    // Upper half-spectrum (top bin bit set) is discarded
                    if (!bin_eff[BinW-1] && ((bin_eff >> BandShift) == BinW'(b))) begin
                        sum      = {1'b0, acc_d[b]} + (ACC_W + 1)'(mag);
                        acc_d[b] = sum[ACC_W] ? AccMax : sum[ACC_W-1:0];
                    end
                end
                bin_d      = bin_eff + BinW'(1);
                in_frame_d = 1'b1;
                if (bus.i_src_eop) begin
                    in_frame_d = 1'b0;
                    if (bin_eff == LastBin) begin
                        bands_valid_d = 1'b1;
                        for (int b = 0; b < NUM_BANDS; b++) begin
`ifdef FFT_SCHED_PEAKHOLD_EN
                            bands_d[b*ACC_W +: ACC_W] =
                                peak_hold(acc_d[b], bands_q[b*ACC_W +: ACC_W]);
`else
                            bands_d[b*ACC_W +: ACC_W] = acc_d[b];
`endif
                        end
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
            end
        end
    end

    // Source-side state and registered band outputs
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int b = 0; b < NUM_BANDS; b++) acc_q[b] <= '0;
            bin_q         <= '0;
            in_frame_q    <= 1'b0;
            bands_q       <= '0;
            bands_valid_q <= 1'b0;
            frame_err_q   <= 1'b0;
            src_ready_q   <= 1'b0;
        end else begin
            acc_q         <= acc_d;
            bin_q         <= bin_d;
            in_frame_q    <= in_frame_d;
            bands_q       <= bands_d;
            bands_valid_q <= bands_valid_d;
            frame_err_q   <= frame_err_d;
            src_ready_q   <= 1'b1;
        end
    end

    assign bus.o_sink_valid  = sink_valid_q;
    assign bus.o_sink_sop    = sink_sop_q;
    assign bus.o_sink_eop    = sink_eop_q;
    assign bus.o_sink_real   = sink_real_q;
    assign bus.o_src_ready   = src_ready_q;
    assign bus.o_bands       = bands_q;
    assign bus.o_bands_valid = bands_valid_q;
    assign bus.o_overflow    = overflow_q;
    assign bus.o_frame_err   = frame_err_q;
endmodule

// File: tb/tb_fft_frame_scheduler.sv
// Directed bench for fft_frame_scheduler: frame sequencing, back-pressure, overflow,
// band reduction, malformed source frames and mid-frame reset.
module tb_fft_frame_scheduler;
    localparam int unsigned FRAME_LEN = 512;
    localparam int unsigned FIFO_AW   = 10;
    localparam int unsigned NUM_BANDS = 4;
    localparam int unsigned ACC_W     = 24;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    fft_frame_scheduler_if #(.NUM_BANDS(NUM_BANDS), .ACC_W(ACC_W)) bus ();

    fft_frame_scheduler #(
        .FRAME_LEN (FRAME_LEN),
        .FIFO_AW   (FIFO_AW),
        .NUM_BANDS (NUM_BANDS),
        .ACC_W     (ACC_W)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [NUM_BANDS*ACC_W-1:0] pack4(input int b0, input int b1,
                                                        input int b2, input int b3);
        logic [NUM_BANDS*ACC_W-1:0] v;
        v = {ACC_W'(b3), ACC_W'(b2), ACC_W'(b1), ACC_W'(b0)};
        return v;
    endfunction

    // One sample per cycle; returns at the negedge after the last write edge
    task automatic write_samples(input int base, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus.i_sample_valid = 1'b1;
            bus.i_sample       = 16'(base + i);
        end
        @(negedge clk);
        bus.i_sample_valid = 1'b0;
    endtask

    // Take n_take sink beats, checking order, delimiters, gaps and stall hold
    task automatic sink_collect(input string tag, input int first_val, input bit toggle,
                                input int n_take, input int max_lat);
        int beats = 0, cyc = 0, first = 0, bad = 0, hold_bad = 0, gaps = 0;
        bit stall = 1'b0;
        bit rdy;
        logic [15:0] p_real;
        logic p_sop, p_eop;
        while (beats < n_take && cyc < 4000) begin
            @(negedge clk);
            cyc++;
            rdy = toggle ? ((cyc % 2) == 1) : 1'b1;
            bus.i_sink_ready = rdy;
            if (stall && (!bus.o_sink_valid || bus.o_sink_real !== p_real ||
                          bus.o_sink_sop !== p_sop || bus.o_sink_eop !== p_eop)) hold_bad++;
            if (bus.o_sink_valid) begin
                if (first == 0) first = cyc;
                if (rdy) begin
                    if (bus.o_sink_real !== 16'(first_val + beats)) bad++;
                    if (bus.o_sink_sop !== (beats == 0)) bad++;
                    if (bus.o_sink_eop !== (beats == FRAME_LEN - 1)) bad++;
                    beats++;
                end
            end else if (first != 0) begin
                gaps++;
            end
            stall  = bus.o_sink_valid && !rdy;
            p_real = bus.o_sink_real;
            p_sop  = bus.o_sink_sop;
            p_eop  = bus.o_sink_eop;
        end
        bus.i_sink_ready = 1'b1;
        check_eq({tag, " beats"}, beats, n_take);
        check_eq({tag, " data/sop/eop errors"}, bad, 0);
        check_eq({tag, " idle cycles in frame"}, gaps, 0);
        check_eq({tag, " start latency ok"}, (first >= 1 && first <= max_lat), 1);
        if (toggle) check_eq({tag, " hold during stall errors"}, hold_bad, 0);
    endtask

    // Source frame of nbins beats; mode 0: (1,-1) 1: zeros 2: ramp (k,-k) 3: (-32768,-32768)
    task automatic src_frame(input int nbins, input int mode, input bit with_eop,
                             output int spurious);
        spurious = 0;
        for (int k = 0; k < nbins; k++) begin
            @(negedge clk);
            if (bus.o_bands_valid || bus.o_frame_err) spurious++;
            bus.i_src_valid = 1'b1;
            bus.i_src_sop   = (k == 0);
            bus.i_src_eop   = with_eop && (k == nbins - 1);
            unique case (mode)
                0: begin bus.i_src_real = 16'sd1;   bus.i_src_imag = -16'sd1; end
                1: begin bus.i_src_real = 16'sd0;   bus.i_src_imag = 16'sd0;  end
                2: begin bus.i_src_real = 16'(k);   bus.i_src_imag = 16'(-k); end
                default: begin bus.i_src_real = 16'h8000; bus.i_src_imag = 16'h8000; end
            endcase
        end
        @(negedge clk);
        bus.i_src_valid = 1'b0;
        bus.i_src_sop   = 1'b0;
        bus.i_src_eop   = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int sp;
        logic [NUM_BANDS*ACC_W-1:0] exp_zero, exp_ramp;
        rst                = 1'b1;
        bus.i_sample_valid = 1'b0;
        bus.i_sample       = '0;
        bus.i_sink_ready   = 1'b1;
        bus.i_src_valid    = 1'b0;
        bus.i_src_sop      = 1'b0;
        bus.i_src_eop      = 1'b0;
        bus.i_src_real     = '0;
        bus.i_src_imag     = '0;

        // Reset values
        repeat (2) @(negedge clk);
        check_eq("reset sink_valid", bus.o_sink_valid, 0);
        check_eq("reset sink_sop", bus.o_sink_sop, 0);
        check_eq("reset sink_eop", bus.o_sink_eop, 0);
        check_eq("reset sink_real", bus.o_sink_real, 0);
        check_eq("reset src_ready", bus.o_src_ready, 0);
        check_eq("reset bands", bus.o_bands, 0);
        check_eq("reset bands_valid", bus.o_bands_valid, 0);
        check_eq("reset overflow", bus.o_overflow, 0);
        check_eq("reset frame_err", bus.o_frame_err, 0);
        rst = 1'b0;
        @(negedge clk);
        check_eq("src_ready after reset", bus.o_src_ready, 1);

        // Source beat before any sop
        bus.i_src_valid = 1'b1;
        bus.i_src_real  = 16'sd5;
        @(negedge clk);
        bus.i_src_valid = 1'b0;
        check_eq("stray beat frame_err", bus.o_frame_err, 1);
        check_eq("stray beat bands_valid", bus.o_bands_valid, 0);
        @(negedge clk);
        check_eq("stray beat frame_err pulse", bus.o_frame_err, 0);
        check_eq("stray beat bands", bus.o_bands, 0);

        // Frame with ready held high
        write_samples(0, FRAME_LEN);
        check_eq("valid one cycle after count reaches frame", bus.o_sink_valid, 0);
        sink_collect("frame1", 0, 1'b0, FRAME_LEN, 1);
        repeat (4) @(negedge clk);
        check_eq("frame1 idle after", bus.o_sink_valid, 0);

        // Frame with toggling ready
        write_samples(0, FRAME_LEN);
        sink_collect("frame2 toggle", 0, 1'b1, FRAME_LEN, 1);
        repeat (4) @(negedge clk);
        check_eq("frame2 FIFO empty after", bus.o_sink_valid, 0);

        // Overflow: 1025 writes with the sink stalled
        bus.i_sink_ready = 1'b0;
        write_samples(0, 1024);
        check_eq("overflow after 1024", bus.o_overflow, 0);
        write_samples(1024, 1);
        check_eq("overflow after 1025", bus.o_overflow, 1);
        repeat (3) @(negedge clk);
        check_eq("overflow sticky", bus.o_overflow, 1);
        sink_collect("ovf frame A", 0, 1'b0, FRAME_LEN, 1);
        sink_collect("ovf frame B back-to-back", 512, 1'b0, FRAME_LEN, 2);
        repeat (4) @(negedge clk);
        check_eq("ovf FIFO empty after", bus.o_sink_valid, 0);
        check_eq("overflow still sticky", bus.o_overflow, 1);

        // Band reduction
        src_frame(FRAME_LEN, 0, 1'b1, sp);
        check_eq("constant frame spurious pulses", sp, 0);
        check_eq("constant frame bands_valid", bus.o_bands_valid, 1);
        check_eq("constant frame bands", bus.o_bands, pack4(128, 128, 128, 128));
        check_eq("constant frame frame_err", bus.o_frame_err, 0);
        @(negedge clk);
        check_eq("bands_valid pulse", bus.o_bands_valid, 0);

`ifdef FFT_SCHED_PEAKHOLD_EN
        exp_zero = pack4(112, 112, 112, 112);
`else
        exp_zero = pack4(0, 0, 0, 0);
`endif
        src_frame(FRAME_LEN, 1, 1'b1, sp);
        check_eq("zero frame bands_valid", bus.o_bands_valid, 1);
        check_eq("zero frame bands", bus.o_bands, exp_zero);
        @(negedge clk);

        src_frame(301, 0, 1'b1, sp);
        check_eq("short frame frame_err", bus.o_frame_err, 1);
        check_eq("short frame bands_valid", bus.o_bands_valid, 0);
        check_eq("short frame bands unchanged", bus.o_bands, exp_zero);
        @(negedge clk);
        check_eq("frame_err pulse", bus.o_frame_err, 0);

        // Partial frame abandoned by a new sop, then a ramp
        src_frame(100, 0, 1'b0, sp);
        exp_ramp = pack4(4032, 12224, 20416, 28608);
        src_frame(FRAME_LEN, 2, 1'b1, sp);
        check_eq("ramp frame spurious pulses", sp, 0);
        check_eq("ramp frame bands_valid", bus.o_bands_valid, 1);
        check_eq("ramp frame bands", bus.o_bands, exp_ramp);
        @(negedge clk);

        src_frame(FRAME_LEN, 3, 1'b1, sp);
        check_eq("full-scale frame bands",
                 bus.o_bands, pack4(4194304, 4194304, 4194304, 4194304));
        @(negedge clk);

        // Reset in the middle of a sink frame
        write_samples(1000, FRAME_LEN);
        sink_collect("pre-reset partial", 1000, 1'b0, 200, 1);
        @(negedge clk);
        check_eq("pre-reset beat 200 value", bus.o_sink_real, 16'(1200));
        rst = 1'b1;
        #1;
        check_eq("mid-frame reset sink_valid", bus.o_sink_valid, 0);
        check_eq("mid-frame reset sink_real", bus.o_sink_real, 0);
        check_eq("mid-frame reset bands", bus.o_bands, 0);
        check_eq("mid-frame reset overflow", bus.o_overflow, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("after reset idle", bus.o_sink_valid, 0);
        write_samples(3000, FRAME_LEN);
        sink_collect("post-reset frame", 3000, 1'b0, FRAME_LEN, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
